add_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit ripple adders.
- Adds or subtracts two WIDTH-bit operands with a carry-in, one SEG_W-bit segment per pipeline stage.
- Carry is registered between stages, so throughput is one operation per clock at any width.
- Sits between producer and consumer datapaths using a valid/ready handshake on both sides.

---
 rtl/add_pipe_if.sv | 34 +++
 rtl/add_pipe.sv | 124 ++++++++++++
 tb/tb_add_pipe.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_pipe_if.sv
// add_pipe_if: handshake/data bundle for add_pipe.
//   producer side : in_valid, in_ready, a, b, ci, sub
//   consumer side : out_valid, out_ready, s, co (+ ovf when ADD_PIPE_OVF_EN)
// Modports:
//   slave  - the adder itself (accepts operands, presents results)
//   master - the surrounding datapath (drives operands, takes results)
// Optional macro: ADD_PIPE_OVF_EN adds the 1-bit signed-overflow flag ovf.
interface add_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef ADD_PIPE_OVF_EN
    logic             ovf;

    modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                    output in_ready, out_valid, s, co, ovf);
    modport master (output in_valid, a, b, ci, sub, out_ready,
                    input  in_ready, out_valid, s, co, ovf);
`else
    modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                    output in_ready, out_valid, s, co);
    modport master (output in_valid, a, b, ci, sub, out_ready,
                    input  in_ready, out_valid, s, co);
`endif
endinterface

// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit adder/subtractor, one SEG_W-bit segment per
// stage, with the carry registered between stages (NSEG = WIDTH/SEG_W stages).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; discards all in-flight beats
//   bus  - add_pipe_if.slave: in_valid/in_ready/a/b/ci/sub on the producer
//          side, out_valid/out_ready/s/co (and ovf) on the consumer side
// Function: {co,s} = a + b' + cin with b' = sub ? ~b : b, cin = sub ? 1 : ci.
// Flow control: one global stall (out_valid && !out_ready) freezes every stage;
// in_ready is simply its inverse, so it never depends on in_valid.
// Optional macro: ADD_PIPE_OVF_EN adds the registered signed-overflow flag ovf.
// WIDTH must be a multiple of SEG_W.
module add_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    add_pipe_if.slave   bus
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int LAST = NSEG - 1;

    logic             stall_s;
    logic [WIDTH-1:0] bp_s;
    logic             cin_s;

    // Per-stage registers. a_r/b_r carry the operands forward so later stages
    // can pick their own segment; sum_r accumulates the finished low segments.
    logic             vld_r [NSEG];
    logic [WIDTH-1:0] a_r   [NSEG];
    logic [WIDTH-1:0] b_r   [NSEG];
    logic [WIDTH-1:0] sum_r [NSEG];
    logic             cy_r  [NSEG];

    // What each stage sees this cycle and what it would load.
    logic             v_in_s   [NSEG];
    logic [WIDTH-1:0] a_in_s   [NSEG];
    logic [WIDTH-1:0] b_in_s   [NSEG];
    logic [WIDTH-1:0] sum_in_s [NSEG];
    logic             c_in_s   [NSEG];
    logic [SEG_W:0]   seg_s    [NSEG];
    logic [WIDTH-1:0] sum_nx_s [NSEG];

    assign stall_s      = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall_s;

    // Subtraction is folded into the operand: A - B = A + ~B + 1.
    assign bp_s  = bus.sub ? ~bus.b : bus.b;
    assign cin_s = bus.sub ? 1'b1 : bus.ci;

    // Route stage inputs (ports for stage 0, previous stage otherwise) and add
    // the stage's own segment on top of the already finished lower bits.
    always_comb begin
        v_in_s[0]   = bus.in_valid;
        a_in_s[0]   = bus.a;
        b_in_s[0]   = bp_s;
        sum_in_s[0] = {WIDTH{1'b0}};
        c_in_s[0]   = cin_s;
        for (int k = 1; k < NSEG; k++) begin
            v_in_s[k]   = vld_r[k-1];
            a_in_s[k]   = a_r[k-1];
            b_in_s[k]   = b_r[k-1];
            sum_in_s[k] = sum_r[k-1];
            c_in_s[k]   = cy_r[k-1];
        end
        for (int k = 0; k < NSEG; k++) begin
            seg_s[k] = {1'b0, a_in_s[k][k*SEG_W +: SEG_W]}
                     + {1'b0, b_in_s[k][k*SEG_W +: SEG_W]}
                     + {{SEG_W{1'b0}}, c_in_s[k]};
            sum_nx_s[k] = sum_in_s[k];
            sum_nx_s[k][k*SEG_W +: SEG_W] = seg_s[k][SEG_W-1:0];
        end
    end

    // Pipeline registers: everything freezes on stall; data only loads behind
    // a valid beat so bubbles never disturb s/co at the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_r[k] <= 1'b0;
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
                sum_r[k] <= {WIDTH{1'b0}};
                cy_r[k]  <= 1'b0;
            end
        end else if (!stall_s) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_r[k] <= v_in_s[k];
                if (v_in_s[k]) begin
                    a_r[k]   <= a_in_s[k];
                    b_r[k]   <= b_in_s[k];
                    sum_r[k] <= sum_nx_s[k];
                    cy_r[k]  <= seg_s[k][SEG_W];
                end
            end
        end
    end

    assign bus.out_valid = vld_r[LAST];
    assign bus.s         = sum_r[LAST];
    assign bus.co        = cy_r[LAST];

`ifdef ADD_PIPE_OVF_EN
    logic ovf_nx_s;
    logic ovf_r;

    // Carry into the MSB is a^b'^sum at that bit; XOR with carry-out flags
    // two's-complement overflow.
    assign ovf_nx_s = a_in_s[LAST][WIDTH-1] ^ b_in_s[LAST][WIDTH-1]
                    ^ seg_s[LAST][SEG_W-1]  ^ seg_s[LAST][SEG_W];

    // Overflow flag, loaded together with the last-stage sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (!stall_s && v_in_s[LAST]) begin
            ovf_r <= ovf_nx_s;
        end
    end

    assign bus.ovf = ovf_r;
`endif
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed self-checking bench for add_pipe.
// Instantiates an 8-bit (2-stage) and a 16-bit (4-stage) adder, both with
// SEG_W=4, sharing clk/rst. Expected values are hand-computed constants.
module tb_add_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    add_pipe_if #(.WIDTH(8))  i8 ();
    add_pipe_if #(.WIDTH(16)) i16 ();

    add_pipe #(.WIDTH(8),  .SEG_W(4)) u_dut8  (.clk(clk), .rst(rst), .bus(i8));
    add_pipe #(.WIDTH(16), .SEG_W(4)) u_dut16 (.clk(clk), .rst(rst), .bus(i16));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] exp_s;
        logic       exp_co;
    } vec_t;

    vec_t tbl [20];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sub);
        i8.in_valid = v;
        i8.a        = a;
        i8.b        = b;
        i8.ci       = ci;
        i8.sub      = sub;
    endtask

    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic sub);
        i16.in_valid = v;
        i16.a        = a;
        i16.b        = b;
        i16.ci       = ci;
        i16.sub      = sub;
    endtask

    // Present one beat for one clock, then wait for it to reach the output.
    task automatic beat8(input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sub);
        drive8(1'b1, a, b, ci, sub);
        step();
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        int  p;
        int  c;
        int  stall_left;
        bit  started;
        bit  acc_in;
        bit  acc_out;

        tbl[0]  = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0};
        tbl[1]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[2]  = '{8'h7F, 8'h80, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[3]  = '{8'h0A, 8'h03, 1'b0, 1'b1, 8'h07, 1'b1};
        tbl[4]  = '{8'h03, 8'h0A, 1'b0, 1'b1, 8'hF9, 1'b0};
        tbl[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[8]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
        tbl[9]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0};
        tbl[10] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0};
        tbl[11] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[12] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1};
        tbl[13] = '{8'h01, 8'h80, 1'b0, 1'b1, 8'h81, 1'b0};
        tbl[14] = '{8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1};
        tbl[15] = '{8'h64, 8'hC8, 1'b0, 1'b1, 8'h9C, 1'b0};
        tbl[16] = '{8'h55, 8'hAA, 1'b0, 1'b1, 8'hAB, 1'b0};
        tbl[17] = '{8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[18] = '{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[19] = '{8'h19, 8'hE6, 1'b0, 1'b0, 8'hFF, 1'b0};

        rst = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        i8.out_ready  = 1'b1;
        i16.out_ready = 1'b1;

        // 1. reset pulse mid-cycle, outputs clear immediately
        #3 rst = 1'b1;
        #1;
        chk("rst_out_valid", i8.out_valid, 1'b0);
        chk("rst_s", i8.s, 8'h00);
        chk("rst_co", i8.co, 1'b0);
        chk("rst_in_ready", i8.in_ready, 1'b1);
        chk("rst16_s", i16.s, 16'h0000);
        #8 rst = 1'b0;
        step();

        // 2. single add, latency 2, valid for exactly one cycle
        drive8(1'b1, 8'h3C, 8'h0F, 1'b1, 1'b0);
        #1;
        chk("add_in_ready", i8.in_ready, 1'b1);
        step();
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("add_lat1_valid", i8.out_valid, 1'b0);
        step();
        chk("add_valid", i8.out_valid, 1'b1);
        chk("add_s", i8.s, 8'h4C);
        chk("add_co", i8.co, 1'b0);
`ifdef ADD_PIPE_OVF_EN
        chk("add_ovf", i8.ovf, 1'b0);
`endif
        step();
        chk("add_one_cycle", i8.out_valid, 1'b0);
        chk("add_s_hold_bubble", i8.s, 8'h4C);

        // 3. wrap-around, subtract, ci ignored on subtract, overflow
        beat8(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("wrap_valid", i8.out_valid, 1'b1);
        chk("wrap_s", i8.s, 8'h00);
        chk("wrap_co", i8.co, 1'b1);
        step();
        beat8(8'h05, 8'h07, 1'b0, 1'b1);
        chk("sub_s", i8.s, 8'hFE);
        chk("sub_co", i8.co, 1'b0);
`ifdef ADD_PIPE_OVF_EN
        chk("sub_ovf", i8.ovf, 1'b0);
`endif
        step();
        beat8(8'h10, 8'h01, 1'b1, 1'b1);
        chk("sub_ci_ign_s", i8.s, 8'h0F);
        chk("sub_ci_ign_co", i8.co, 1'b1);
        step();
        beat8(8'h7F, 8'h01, 1'b0, 1'b0);
        chk("ovf_s", i8.s, 8'h80);
        chk("ovf_co", i8.co, 1'b0);
`ifdef ADD_PIPE_OVF_EN
        chk("ovf_flag", i8.ovf, 1'b1);
`endif
        step();

        // 4. streaming 20 back-to-back beats, one result per clock
        drive8(1'b1, tbl[0].a, tbl[0].b, tbl[0].ci, tbl[0].sub);
        for (int k = 1; k <= 22; k++) begin
            step();
            if (k >= 2 && k <= 21) begin
                chk("stream_valid", i8.out_valid, 1'b1);
                chk("stream_s", i8.s, tbl[k-2].exp_s);
                chk("stream_co", i8.co, tbl[k-2].exp_co);
            end
            if (k == 22) begin
                chk("stream_drained", i8.out_valid, 1'b0);
            end
            if (k < 20) begin
                drive8(1'b1, tbl[k].a, tbl[k].b, tbl[k].ci, tbl[k].sub);
            end else begin
                drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            end
        end

        // 5. backpressure: 3 cycles of out_ready=0 while a result is waiting
        p = 0;
        c = 0;
        stall_left = 0;
        started = 1'b0;
        for (int cyc = 0; cyc < 60 && c < 8; cyc++) begin
            if (!started && i8.out_valid === 1'b1 && c == 2) begin
                started = 1'b1;
                stall_left = 3;
            end
            i8.out_ready = (stall_left == 0);
            if (p < 8) begin
                drive8(1'b1, tbl[8+p].a, tbl[8+p].b, tbl[8+p].ci, tbl[8+p].sub);
            end else begin
                drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            end
            #1;
            if (stall_left > 0) begin
                chk("bp_in_ready_low", i8.in_ready, 1'b0);
                chk("bp_valid_held", i8.out_valid, 1'b1);
            end else begin
                chk("bp_in_ready_high", i8.in_ready, 1'b1);
            end
            if (i8.out_valid === 1'b1) begin
                chk("bp_s", i8.s, tbl[8+c].exp_s);
                chk("bp_co", i8.co, tbl[8+c].exp_co);
            end
            acc_in  = i8.in_valid && i8.in_ready;
            acc_out = i8.out_valid && i8.out_ready;
            step();
            if (acc_in) p++;
            if (acc_out) c++;
            if (stall_left > 0) stall_left--;
        end
        chk("bp_all_consumed", c, 8);
        chk("bp_all_accepted", p, 8);
        chk("bp_stall_seen", started, 1'b1);
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        i8.out_ready = 1'b1;
        step();
        chk("bp_drained", i8.out_valid, 1'b0);

        // 6. reset with 3 beats in flight in the 4-stage adder
        drive16(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        step();
        drive16(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0);
        step();
        drive16(1'b1, 16'h5555, 16'h6666, 1'b1, 1'b0);
        step();
        drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("mid_inflight_no_out", i16.out_valid, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", i16.out_valid, 1'b0);
        chk("mid_rst_s", i16.s, 16'h0000);
        chk("mid_rst_in_ready", i16.in_ready, 1'b1);
        #2 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mid_post_rst_idle", i16.out_valid, 1'b0);
        end
        drive16(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            if (k < 4) begin
                chk("w16_latency", i16.out_valid, 1'b0);
            end else begin
                chk("w16_valid", i16.out_valid, 1'b1);
                chk("w16_s", i16.s, 16'h2234);
                chk("w16_co", i16.co, 1'b0);
            end
        end
        drive16(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        step();
        drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("w16_sub_valid", i16.out_valid, 1'b1);
        chk("w16_sub_s", i16.s, 16'h7FFF);
        chk("w16_sub_co", i16.co, 1'b1);
`ifdef ADD_PIPE_OVF_EN
        chk("w16_sub_ovf", i16.ovf, 1'b1);
`endif
        step();
        chk("w16_drained", i16.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
